// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the Wishbone port onto the byte-banked user RAM.
package wb_ram_pkg;
  localparam int RAM_ROWS  = 512;
  localparam int NUM_BANKS = 8;
  localparam int NUM_LANES = 4;
  localparam int ROW_W     = $clog2(RAM_ROWS);

  typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_ISSUE, ST_CAPT, ST_ACK} state_e;

  // Word half (byte offset bit 2) picks the upper or lower group of four banks.
  function automatic logic [2:0] bank_sel(input logic half, input logic [1:0] lane);
    return {half, lane};
  endfunction
endpackage

// File: rtl/wb_ram_lane_seq.sv
// Picks the next byte lane to write from the remaining-lanes mask.
module wb_ram_lane_seq
  import wb_ram_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  output logic [1:0]           lane,
  output logic [NUM_LANES-1:0] rest
);
  always_comb begin
    lane = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (mask[k]) lane = k[1:0];
    rest = mask & (mask - 1'b1);
  end
endmodule

// File: rtl/wb_ram_port.sv
// Wishbone classic responder driving the 8-bank user RAM macros after an arbiter grant.
// Optional WB_RAM_ERR_EN adds wbs_err_o and answers out-of-range accesses with an error.
module wb_ram_port
  import wb_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RAM_BYTES = 4096
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
`ifdef WB_RAM_ERR_EN
  output logic                 wbs_err_o,
`endif
  output logic [31:0]          wbs_dat_o,
  output logic                 ram_req_o,
  input  logic                 ram_gnt_i,
  output logic                 ram_cen_o,
  output logic [ROW_W-1:0]     ram_a_o,
  output logic [7:0]           ram_d_o,
  output logic [NUM_BANKS-1:0] ram_gwen_o,
  input  logic [63:0]          ram_q_i
);
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q;
  logic                 half_q, we_q, miss_q;
  logic [NUM_LANES-1:0] mask_q, mask_rest;
  logic [31:0]          wdat_q, off;
  logic [1:0]           lane;
  logic                 hit, start, resp;
  logic                 unused_off;

  assign off        = wbs_adr_i - BASE_ADDR;
  assign hit        = (wbs_adr_i >= BASE_ADDR) && (off < 32'(RAM_BYTES));
  assign start      = wbs_cyc_i && wbs_stb_i;
  assign unused_off = ^off[1:0];
  assign ram_a_o    = row_q;

  wb_ram_lane_seq u_lane_seq (.mask(mask_q), .lane(lane), .rest(mask_rest));

  always_comb begin
    state_d    = state_q;
    ram_req_o  = 1'b0;
    ram_cen_o  = 1'b1;
    ram_gwen_o = '1;
    ram_d_o    = '0;
    resp       = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        if (!hit || (wbs_we_i && wbs_sel_i == '0)) state_d = ST_ACK;
        else                                       state_d = ST_ARB;
      end
      ST_ARB: begin
        ram_req_o = 1'b1;
        if (!wbs_cyc_i)     state_d = ST_IDLE;
        else if (ram_gnt_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        ram_req_o = 1'b1;
        ram_cen_o = 1'b0;
        if (we_q) begin
          // One lane per macro cycle since all banks share the D bus.
          ram_d_o = wdat_q[{lane, 3'b000} +: 8];
          ram_gwen_o[bank_sel(half_q, lane)] = 1'b0;
          if (!wbs_cyc_i)            state_d = ST_IDLE;
          else if (mask_rest == '0)  state_d = ST_ACK;
        end else begin
          state_d = wbs_cyc_i ? ST_CAPT : ST_IDLE;
        end
      end
      ST_CAPT: begin
        ram_req_o = 1'b1;
        state_d   = wbs_cyc_i ? ST_ACK : ST_IDLE;
      end
      ST_ACK: begin
        resp    = wbs_cyc_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbs_ack_o = resp && !(ERR_EN && miss_q);
`ifdef WB_RAM_ERR_EN
  assign wbs_err_o = resp && miss_q;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      half_q    <= 1'b0;
      we_q      <= 1'b0;
      miss_q    <= 1'b0;
      mask_q    <= '0;
      wdat_q    <= '0;
      wbs_dat_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        miss_q <= !hit;
        we_q   <= wbs_we_i;
        mask_q <= wbs_sel_i;
        wdat_q <= wbs_dat_i;
        if (hit) begin
          row_q  <= off[ROW_W+2:3];
          half_q <= off[2];
        end
        if (!hit && !wbs_we_i && !ERR_EN) wbs_dat_o <= '0;
      end
      if (state_q == ST_ISSUE && we_q) mask_q <= mask_rest;
      // Every lane comes back on reads, selected or not.
      if (state_q == ST_CAPT && wbs_cyc_i)
        for (int k = 0; k < NUM_LANES; k++)
          wbs_dat_o[8*k +: 8] <= ram_q_i[{bank_sel(half_q, 2'(k)), 3'b000} +: 8];
    end
  end
endmodule

// File: tb/tb_wb_ram_port.sv
// Self-checking bench for wb_ram_port: byte-array reference model, vector table, corner sequences, random traffic.
module tb_wb_ram_port;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 0, stb = 0, we = 0, gnt = 1;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, wdat = 0;
  logic        ack, err, ram_req, ram_cen;
  logic [31:0] dat_o;
  logic [8:0]  ram_a;
  logic [7:0]  ram_d, ram_gwen;
  logic [63:0] q;

  always #5 clk = ~clk;

  wb_ram_port dut (
    .wb_clk_i(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack),
`ifdef WB_RAM_ERR_EN
    .wbs_err_o(err),
`endif
    .wbs_dat_o(dat_o), .ram_req_o(ram_req), .ram_gnt_i(gnt), .ram_cen_o(ram_cen),
    .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_gwen_o(ram_gwen), .ram_q_i(q)
  );
`ifndef WB_RAM_ERR_EN
  assign err = 1'b0;
`endif

  // Macro model: flat byte array indexed by {row, bank}, registered Q output.
  logic [7:0]  mem [4096];
  logic        pre_en = 0;
  logic [11:0] pre_addr = 0;
  logic [7:0]  pre_data = 0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!ram_cen)
      for (int b = 0; b < 8; b++) begin
        if (!ram_gwen[b]) mem[{ram_a, 3'(b)}] <= ram_d;
        q[b*8 +: 8] <= mem[{ram_a, 3'(b)}];
      end
  end

  // Reference: Wishbone-level byte memory plus the expected read-data register.
  logic [7:0]  ref_mem [4096];
  logic [31:0] exp_dato = 0;
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  cap_gwen[$], cap_d[$];
  logic [8:0]  cap_a[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pre_en = 1; pre_addr = 12'(a); pre_data = d; ref_mem[a] = d;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd4096);
  endfunction

  task automatic run_check(input string nm, input bit w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int lat, output logic [31:0] rd);
    bit h, e_req, req_seen, tmo;
    int pc, e_lat, e_cen, ncen;
    logic [11:0] o;
    logic [31:0] e_word;
    h = is_hit(a); pc = $countones(s); o = 12'(a - BASE) & 12'hFFC;
    e_word = {ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]};
    if (!h || (w && s == 0)) begin e_lat = 1; e_cen = 0; e_req = 0; end
    else if (!w)             begin e_lat = 4; e_cen = 1; e_req = 1; end
    else                     begin e_lat = 2 + pc; e_cen = pc; e_req = 1; end
    cap_gwen.delete(); cap_d.delete(); cap_a.delete();
    cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
    lat = 0; ncen = 0; req_seen = 0; tmo = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ram_req) req_seen = 1;
      if (!ram_cen) begin ncen++; cap_gwen.push_back(ram_gwen); cap_d.push_back(ram_d); cap_a.push_back(ram_a); end
      if (ack || err) begin tmo = 0; break; end
    end
    rd = dat_o;
    chk({nm, " timeout"}, 64'(tmo), 0);
    chk({nm, " latency"}, 64'(lat), 64'(e_lat));
    chk({nm, " macro cycles"}, 64'(ncen), 64'(e_cen));
    chk({nm, " req"}, 64'(req_seen), 64'(e_req));
    chk({nm, " err"}, 64'(err), 64'(ERR_MODE && !h));
    if (h && w) for (int k = 0; k < 4; k++) if (s[k]) ref_mem[o + 12'(k)] = d[8*k +: 8];
    if (h && !w) exp_dato = e_word;
    else if (!h && !w && !ERR_MODE) exp_dato = 0;
    chk({nm, " dat_o"}, 64'(rd), 64'(exp_dato));
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    int          lat;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int lat, cnt, bad, nc, na;
    logic [31:0] rd, ra;
    tbl[0] = '{0, BASE + 32'h10,   4'b0001, 32'h0,        4, 32'hA1B2C3D4};
    tbl[1] = '{1, BASE + 32'h8,    4'b0000, 32'h12345678, 1, 32'h0};
    tbl[2] = '{0, BASE + 32'h1000, 4'b1111, 32'h0,        1, 32'h0};
    tbl[3] = '{1, BASE - 32'h4,    4'b1111, 32'h55555555, 1, 32'h0};
    tbl[4] = '{1, BASE + 32'hFFC,  4'b1111, 32'h01020304, 6, 32'h0};
    tbl[5] = '{0, BASE + 32'hFFC,  4'b0000, 32'h0,        4, 32'h01020304};
    tbl[6] = '{1, BASE + 32'h20,   4'b0100, 32'h00770000, 3, 32'h0};
    tbl[7] = '{1, BASE,            4'b1001, 32'h9900AA88, 4, 32'h0};

    #12;
    chk("reset ack", 64'(ack), 0);
    chk("reset dat_o", 64'(dat_o), 0);
    chk("reset req", 64'(ram_req), 0);
    chk("reset cen", 64'(ram_cen), 1);
    chk("reset gwen", 64'(ram_gwen), 64'hFF);
    chk("reset a/d", 64'({ram_a, ram_d}), 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4096; i++) preload(i, 8'($urandom));
    preload(32'h14, 8'h11); preload(32'h15, 8'h22); preload(32'h16, 8'h33); preload(32'h17, 8'h44);

    run_check("rd 0x14", 0, BASE + 32'h14, 4'hF, 0, lat, rd);
    chk("rd 0x14 value", 64'(rd), 64'h44332211);

    run_check("wr 0x10", 1, BASE + 32'h10, 4'hF, 32'hA1B2C3D4, lat, rd);
    if (cap_gwen.size() == 4) begin
      chk("wr 0x10 gwen", 64'({cap_gwen[0], cap_gwen[1], cap_gwen[2], cap_gwen[3]}), 64'hFEFDFBF7);
      chk("wr 0x10 d", 64'({cap_d[0], cap_d[1], cap_d[2], cap_d[3]}), 64'hD4C3B2A1);
      chk("wr 0x10 a", 64'({cap_a[0], cap_a[3]}), 64'({9'd2, 9'd2}));
    end else chk("wr 0x10 issue count", 64'(cap_gwen.size()), 4);

    run_check("wr 0x4 clr", 1, BASE + 32'h4, 4'hF, 32'h0, lat, rd);
    run_check("wr 0x4 sel A", 1, BASE + 32'h4, 4'b1010, 32'hDEADBEEF, lat, rd);
    if (cap_gwen.size() == 2) begin
      chk("wr 0x4 gwen", 64'({cap_gwen[0], cap_gwen[1]}), 64'hDF7F);
      chk("wr 0x4 d", 64'({cap_d[0], cap_d[1]}), 64'hBEDE);
    end else chk("wr 0x4 issue count", 64'(cap_gwen.size()), 2);
    run_check("rd 0x4", 0, BASE + 32'h4, 4'hF, 0, lat, rd);
    chk("rd 0x4 value", 64'(rd), 64'hDE00BE00);

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, lat, rd);
      chk($sformatf("vec%0d table latency", i), 64'(lat), 64'(tbl[i].lat));
      if (!tbl[i].w && (is_hit(tbl[i].a) || !ERR_MODE))
        chk($sformatf("vec%0d table data", i), 64'(rd), 64'(tbl[i].rd));
    end

    // Grant withheld for 5 cycles during a read.
    gnt = 0; cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!ram_req || !ram_cen || ack) bad++;
    end
    chk("stall req/cen", 64'(bad), 0);
    gnt = 1; cnt = 0;
    for (int i = 0; i < 20 && !ack; i++) begin @(posedge clk); #1; cnt++; end
    chk("stall ack delay", 64'(cnt), 3);
    exp_dato = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
    chk("stall dat_o", 64'(dat_o), 64'(exp_dato));
    cyc = 0; stb = 0;
    @(posedge clk); #1;

    // cyc dropped during the 2nd lane of a 4-lane write.
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h40; sel = 4'hF; wdat = 32'hCAFEF00D;
    nc = 0; na = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (!ram_cen) nc++; end
    cyc = 0; stb = 0; we = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (!ram_cen) nc++; if (ack || err) na++; end
    chk("abort macro cycles", 64'(nc), 2);
    chk("abort no ack", 64'(na), 0);
    ref_mem[12'h40] = 8'h0D; ref_mem[12'h41] = 8'hF0;
    run_check("abort readback", 0, BASE + 32'h40, 4'hF, 0, lat, rd);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = BASE + 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        1:       ra = BASE - 32'($urandom_range(1, 64)) * 4;
        default: ra = BASE + 32'h100 + 32'($urandom_range(0, 31)) * 4;
      endcase
      run_check($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), ra, 4'($urandom), $urandom, lat, rd);
    end

    // Reset during the 2nd ISSUE cycle of a full write.
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h80; sel = 4'hF; wdat = 32'h13579BDF;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("pre-reset in issue", 64'(ram_cen), 0);
    rst_n = 0; #1;
    chk("mid reset cen", 64'(ram_cen), 1);
    chk("mid reset gwen", 64'(ram_gwen), 64'hFF);
    chk("mid reset ack/req", 64'({ack, ram_req}), 0);
    cyc = 0; stb = 0; we = 0; exp_dato = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    run_check("post reset rd", 0, BASE + 32'h10, 4'hF, 0, lat, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
